// File: rtl/sub_pkg.sv
// Shared sizing and state encoding for the slice-serial subtractor.
// Build option SUB_SLT_EN (see sub_serial) does not affect this package.
package sub_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 4;
    localparam int NSLICE    = DEF_WIDTH / DEF_SLICE;
    localparam int CNT_W     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit slice of A + ~B + cin; zero latency, no handshake.
module sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] d,
    output logic         cout
);
    assign {cout, d} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/sub_serial.sv
// Slice-serial subtractor S = A - B with Z/V/N flags; done pulses NSLICE cycles after accept.
// Define SUB_SLT_EN to add the registered set-less-than output LT.
module sub_serial
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sign,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Z,
    output logic             V,
    output logic             N
`ifdef SUB_SLT_EN
    ,
    output logic             LT
`endif
);
    localparam int NS   = WIDTH / SLICE;
    localparam int CW   = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d, v_q, v_d, n_q, n_d;
    logic [SLICE-1:0] sl_a, sl_b, sl_d;
    logic             sl_cout;
    logic             v_new, s_msb;

    assign sl_a = a_q[cnt_q*SLICE +: SLICE];
    assign sl_b = b_q[cnt_q*SLICE +: SLICE];

    sub_slice #(.W(SLICE)) u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .d    (sl_d),
        .cout (sl_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        work_d  = work_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        s_d     = s_q;
        z_d     = z_q;
        v_d     = v_q;
        n_d     = n_q;
        v_new   = 1'b0;
        s_msb   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sign_d  = Sign;
                    cnt_d   = '0;
                    carry_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d[cnt_q*SLICE +: SLICE] = sl_d;
                carry_d = sl_cout;
                if (cnt_q == LAST) begin
                    // Flags use the fully assembled result including this edge's slice.
                    s_msb   = work_d[WIDTH-1];
                    v_new   = sign_q ? ((a_q[WIDTH-1] != b_q[WIDTH-1]) && (s_msb != a_q[WIDTH-1]))
                                     : ~sl_cout;
                    s_d     = work_d;
                    z_d     = (work_d == '0);
                    v_d     = v_new;
                    n_d     = sign_q & (s_msb ^ v_new);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            s_q     <= s_d;
            z_q     <= z_d;
            v_q     <= v_d;
            n_q     <= n_d;
        end
    end

`ifdef SUB_SLT_EN
    logic lt_q, lt_d;
    assign lt_d = done_d ? (sign_q ? n_d : v_d) : lt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lt_q <= 1'b0;
        else       lt_q <= lt_d;
    end
    assign LT = lt_q;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign Z    = z_q;
    assign V    = v_q;
    assign N    = n_q;
endmodule
